// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the fifo_pop_arbiter block.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    STALL  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_FIFOS = 4;
  localparam int DEF_DATA_SIZE = 6;

endpackage

// File: rtl/fifo_pop_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr, wrapping.
// The pointer wraps for free because NUM_FIFOS is a power of two.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int SEL_SIZE  = $clog2(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [SEL_SIZE-1:0]  rr,
  output logic [SEL_SIZE-1:0]  grant,
  output logic                 valid
);

  logic [SEL_SIZE-1:0] idx;

  // Scan from the farthest offset down so the closest request to rr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
      idx = rr + SEL_SIZE'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop scheduler draining NUM_FIFOS source FIFOs into one downstream FIFO.
// Define FIFO_ARB_URGENT_EN to give sources flagging almost_full priority.
module fifo_pop_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int SEL_SIZE  = $clog2(NUM_FIFOS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFOS-1:0]           src_empty,
  input  logic [NUM_FIFOS-1:0]           src_almost_full,
  input  logic [NUM_FIFOS*DATA_SIZE-1:0] src_data,
  input  logic                           dst_almost_full,
  output logic [NUM_FIFOS-1:0]           src_pop,
  output logic                           dst_push,
  output logic [DATA_SIZE-1:0]           dst_data,
  output logic [SEL_SIZE-1:0]            dst_sel,
  output logic [1:0]                     arb_state
);

  arb_state_t           state_q, state_d;
  logic [NUM_FIFOS-1:0] pop_d;
  logic [NUM_FIFOS-1:0] eligible;
  logic [NUM_FIFOS-1:0] req;
  logic [SEL_SIZE-1:0]  rr_q;
  logic [SEL_SIZE-1:0]  grant;
  logic                 grant_valid;
  logic [SEL_SIZE-1:0]  grant_q;
  logic [SEL_SIZE-1:0]  sel_pipe_q;
  logic                 pop_pipe_q;
  logic [DATA_SIZE-1:0] src_word;

  // A source popped last cycle still shows a stale empty flag, so mask it out.
  assign eligible = ~src_empty & ~src_pop;

`ifdef FIFO_ARB_URGENT_EN
  logic [NUM_FIFOS-1:0] urgent;
  assign urgent = eligible & src_almost_full;
  assign req    = (|urgent) ? urgent : eligible;
`else
  logic unused_almost_full;
  assign unused_almost_full = ^src_almost_full;
  assign req = eligible;
`endif

  rr_pick #(
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_SIZE  (SEL_SIZE)
  ) u_rr_pick (
    .req   (req),
    .rr    (rr_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    pop_d   = '0;
    case (state_q)
      INIT: state_d = IDLE;
      default: begin
        if (!grant_valid) begin
          state_d = IDLE;
        end else if (dst_almost_full) begin
          state_d = STALL;
        end else begin
          state_d      = ACTIVE;
          pop_d[grant] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (sel_pipe_q == SEL_SIZE'(i)) begin
        src_word = src_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Grant index rides alongside src_pop, then one more stage to meet the source read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_pop    <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      sel_pipe_q <= '0;
      pop_pipe_q <= 1'b0;
      dst_push   <= 1'b0;
      dst_data   <= '0;
      dst_sel    <= '0;
    end else begin
      src_pop <= pop_d;
      if (state_d == ACTIVE) begin
        rr_q    <= grant + SEL_SIZE'(1);
        grant_q <= grant;
      end
      pop_pipe_q <= |src_pop;
      sel_pipe_q <= grant_q;
      dst_push   <= pop_pipe_q;
      if (pop_pipe_q) begin
        dst_data <= src_word;
        dst_sel  <= sel_pipe_q;
      end
    end
  end

  assign arb_state = state_q;

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Round-robin pop scheduler that drains NUM_FIFOS per-channel FIFOs into one shared downstream FIFO. Watches each source FIFO's empty and almost_full flags plus the downstream almost_full flag. Issues at most one pop per cycle and forwards the popped word with its source index. Sits between the per-channel FIFO bank and the shared output FIFO.

## Interface
- NUM_FIFOS, 4, number of source FIFOs (power of two, 2..8)
- DATA_SIZE, 6, word width
- SEL_SIZE, $clog2(NUM_FIFOS), width of source index
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- src_empty  in  NUM_FIFOS  per-source fifo_empty flag
- src_almost_full  in  NUM_FIFOS  per-source almost_full flag
- src_data  in  NUM_FIFOS*DATA_SIZE  per-source read data; source i at bits [i*DATA_SIZE +: DATA_SIZE]; valid the cycle after its pop
- dst_almost_full  in  1  downstream almost_full flag
- src_pop  out  NUM_FIFOS  registered one-hot pop strobe
- dst_push  out  1  registered push strobe to downstream
- dst_data  out  DATA_SIZE  registered word to downstream
- dst_sel  out  SEL_SIZE  registered source index accompanying dst_data
- arb_state  out  2  current FSM state

## Operation
- FSM states, with encodings: INIT=0, IDLE=1, ACTIVE=2, STALL=3.
- INIT: occupies exactly one cycle after reset release, then moves to IDLE. No pops in INIT.
- Eligibility of source i:
  - ~src_empty[i];
  - i was not granted in the previous cycle. Its empty flag is stale for one cycle after a pop.
- Choosing the next state each cycle (from IDLE, ACTIVE or STALL):
  - no eligible source -> IDLE;
  - eligible source present and dst_almost_full=1 -> STALL;
  - otherwise -> ACTIVE, with grant g.
- Entering ACTIVE registers src_pop = one-hot(g). src_pop is zero in every other state.
- Grant selection: round-robin pointer rr (SEL_SIZE bits, reset 0).
  - Search starts at rr and wraps modulo NUM_FIFOS.
  - After a grant, rr <= g+1, wrapping from NUM_FIFOS-1 to 0.
- Urgent priority (see Configuration): if any eligible source has src_almost_full=1, the round-robin search covers only those urgent sources.
- Forwarding: one cycle after src_pop[g] is high:
  - dst_data <= src_data[g];
  - dst_sel <= g;
  - dst_push <= 1.
  - The grant index is pipelined one stage for this.
- Backpressure: dst_almost_full is checked only when issuing a pop. Words already in flight (at most 2) are always pushed. The downstream almost_full threshold must leave at least 2 free entries.
- Reset values:
  - src_pop=0, dst_push=0, dst_data=0, dst_sel=0;
  - arb_state=INIT, rr=0;
  - pipelined grant index = 0, last-grant mask = 0.
- Reset mid-operation: all outputs clear asynchronously and in-flight words are dropped. The source FIFOs are reset by the same signal.

## Timing
- Pop-to-push latency: pop at cycle c -> dst_push/dst_data/dst_sel valid at cycle c+2. This is one cycle of source read latency plus one register.
- Throughput:
  - one word per cycle when at least 2 sources are non-empty;
  - one word per 2 cycles when a single source is non-empty.
- dst_almost_full rising at cycle c -> no src_pop at c+1. At most 2 further dst_push follow.
- Simultaneous urgent and non-urgent requests: an urgent source always wins the same-cycle grant. rr still advances past the winner.
- All outputs are flops. There is no combinational path from inputs to outputs.

## Configuration
- FIFO_ARB_URGENT_EN defined: urgent priority on src_almost_full is active, as described above.
- FIFO_ARB_URGENT_EN undefined: src_almost_full is ignored and arbitration is pure round-robin. The port remains present.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (INIT/IDLE/ACTIVE/STALL) and its 2-bit encoding;
  - default NUM_FIFOS and DATA_SIZE constants.
- Sub-module rr_pick: combinational masked round-robin picker. It takes a request vector and the rr pointer and returns a grant index plus a valid bit. It is instantiated once, fed by the urgent-or-eligible request vector.

## Test plan
- Reset held 3 cycles then released -> every output 0 and arb_state=INIT for 1 cycle, then IDLE. No pop while all src_empty=1111.
- Sources 0..3 each hold 3 words (0x10+i*4+k), dst_almost_full=0:
  - pops granted 0,1,2,3,0,1,... continuously;
  - dst_sel follows the same sequence 2 cycles later;
  - 12 pushes total, all data in order per source.
- Only source 2 non-empty, holding 4 words -> src_pop=0100 every other cycle, 4 pushes with dst_sel=2, no pop on empty.
- dst_almost_full raised mid-stream -> arb_state=STALL next cycle, zero new pops, at most 2 trailing pushes. Lowering it resumes from the current rr.
- With FIFO_ARB_URGENT_EN, rr=0, sources 0 and 3 non-empty, src_almost_full=1000 -> source 3 granted first, then source 0. Without the macro -> source 0 first.
- reset asserted while 2 words are in flight -> dst_push=0 immediately, no push of those words after release, rr=0.
